// File: rtl/ddr2_mem_responder_dummy_if.sv
// Cache/DDR2 request bus: one command in flight, single-cycle ready pulse.
interface ddr2_mem_responder_dummy_if;
    localparam int unsigned DATA_W = 256;
    localparam int unsigned ADDR_W = 28;

    logic [DATA_W-1:0] mem_data_wr1;
    logic [DATA_W-1:0] mem_data_rd1;
    logic [ADDR_W-1:0] mem_data_addr1;
    logic              mem_rw_data1;
    logic              mem_valid_data1;
    logic              mem_ready_data1;

    // Initiator side (cache)
    modport master (
        output mem_data_wr1, mem_data_addr1, mem_rw_data1, mem_valid_data1,
        input  mem_data_rd1, mem_ready_data1
    );

    // Responder side (memory model)
    modport slave (
        input  mem_data_wr1, mem_data_addr1, mem_rw_data1, mem_valid_data1,
        output mem_data_rd1, mem_ready_data1
    );
endinterface

// File: rtl/ddr2_mem_responder_dummy.sv
// Behavioural DDR2 stand-in: fully-associative line store with fixed
// response latency and sticky miss/overflow/protocol status flags.
module ddr2_mem_responder_dummy #(
    parameter int unsigned LATENCY = 4,
    parameter int unsigned DEPTH   = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    ddr2_mem_responder_dummy_if.slave     bus,
    output logic                          rd_miss,
    output logic                          wr_overflow,
    output logic                          proto_err,
    output logic [5:0]                    entries_used
);
    localparam int unsigned DATA_W = 256;
    localparam int unsigned ADDR_W = 28;
    localparam int unsigned CNT_W  = 8;
    localparam int unsigned IDX_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

    state_t             state, state_nx;
    logic [CNT_W-1:0]   cnt, cnt_nx;
    logic               latch_c;
    logic               proto_c;
    logic               commit_c;

    logic               req_rw;
    logic [ADDR_W-1:0]  req_addr;
    logic [DATA_W-1:0]  req_wdata;

    logic               eff_rw_c;
    logic [ADDR_W-1:0]  eff_addr_c;
    logic [DATA_W-1:0]  eff_wdata_c;

    logic [DEPTH-1:0]   ent_vld;
    logic [ADDR_W-1:0]  ent_tag  [DEPTH];
    logic [DATA_W-1:0]  ent_data [DEPTH];

    logic               hit_c;
    logic [IDX_W-1:0]   hit_idx_c;
    logic               free_c;
    logic [IDX_W-1:0]   free_idx_c;

    logic               ready_q;
    logic [DATA_W-1:0]  rd_q;

    assign bus.mem_ready_data1 = ready_q;
    assign bus.mem_data_rd1    = rd_q;

    // With LATENCY=1 the store is updated on the accepting edge itself,
    // before the request registers are loaded, so use the live bus in IDLE.
    assign eff_rw_c    = (state == IDLE) ? bus.mem_rw_data1   : req_rw;
    assign eff_addr_c  = (state == IDLE) ? bus.mem_data_addr1 : req_addr;
    assign eff_wdata_c = (state == IDLE) ? bus.mem_data_wr1   : req_wdata;

    // Next-state, latency counter and protocol check
    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        latch_c  = 1'b0;
        proto_c  = 1'b0;
        case (state)
            IDLE: begin
                if (bus.mem_valid_data1) begin
                    latch_c  = 1'b1;
                    cnt_nx   = CNT_W'(1);
                    state_nx = (LATENCY == 1) ? RESP : BUSY;
                end
            end
            BUSY: begin
                cnt_nx = cnt + CNT_W'(1);
                if (!bus.mem_valid_data1 || (bus.mem_rw_data1 != req_rw) ||
                    (bus.mem_data_addr1 != req_addr) || (bus.mem_data_wr1 != req_wdata))
                    proto_c = 1'b1;
                if (cnt == CNT_W'(LATENCY - 1))
                    state_nx = RESP;
            end
            RESP:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    assign commit_c = (state_nx == RESP);

    // Tag match against all valid entries
    always_comb begin
        hit_c     = 1'b0;
        hit_idx_c = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (ent_vld[i] && (ent_tag[i] == eff_addr_c)) begin
                hit_c     = 1'b1;
                hit_idx_c = IDX_W'(i);
            end
        end
    end

    // Lowest-index free entry (scan downward so the lowest wins)
    always_comb begin
        free_c     = 1'b0;
        free_idx_c = '0;
        for (int i = int'(DEPTH) - 1; i >= 0; i--) begin
            if (!ent_vld[i]) begin
                free_c     = 1'b1;
                free_idx_c = IDX_W'(i);
            end
        end
    end

    // Control state, valid bits, read data and sticky flags
    always_ff @(posedge clk) begin
        if (!rst) begin
            state        <= IDLE;
            cnt          <= '0;
            ready_q      <= 1'b0;
            rd_q         <= '0;
            ent_vld      <= '0;
            entries_used <= '0;
            rd_miss      <= 1'b0;
            wr_overflow  <= 1'b0;
            proto_err    <= 1'b0;
        end else begin
            state   <= state_nx;
            cnt     <= cnt_nx;
            ready_q <= commit_c;
            if (proto_c)
                proto_err <= 1'b1;
            if (commit_c) begin
                if (eff_rw_c) begin
                    if (!hit_c) begin
                        if (free_c) begin
                            ent_vld[free_idx_c] <= 1'b1;
                            entries_used        <= entries_used + 6'd1;
                        end else begin
                            wr_overflow <= 1'b1;
                        end
                    end
                end else if (hit_c) begin
                    rd_q <= ent_data[hit_idx_c];
                end else begin
                    rd_q    <= '0;
                    rd_miss <= 1'b1;
                end
            end
        end
    end

    // Request capture and entry payload; contents are don't-care after reset
    always_ff @(posedge clk) begin
        if (latch_c) begin
            req_rw    <= bus.mem_rw_data1;
            req_addr  <= bus.mem_data_addr1;
            req_wdata <= bus.mem_data_wr1;
        end
        if (commit_c && eff_rw_c) begin
            if (hit_c) begin
                ent_data[hit_idx_c] <= eff_wdata_c;
            end else if (free_c) begin
                ent_tag[free_idx_c]  <= eff_addr_c;
                ent_data[free_idx_c] <= eff_wdata_c;
            end
        end
    end
endmodule
